fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 134 +++++++++++++
 tb/tb_fetch_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: PC walk, prefetch FIFO, redirect flush, start/halt.
// Optional FETCH_STATS_EN adds saturating fetch/redirect counters.
module fetch_sequencer #(
   parameter int          DEPTH      = 2,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        halt,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        branch_taken,
   input  logic [31:0] branch_target
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] fetch_count,
   output logic [15:0] redirect_count
`endif
   ,
   output logic        busy
);

   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] SPAN     = 32'(IMEM_WORDS * 4);
   localparam logic [31:0] LAST     = SPAN - 32'd4;
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
   localparam logic [31:0] PC_RST   = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HALTED} state_t;

   state_t        state, state_nxt;
   logic [31:0]   pc, pc_nxt;
   logic [31:0]   fifo_data [DEPTH];
   logic [31:0]   fifo_pc   [DEPTH];
   logic [AW-1:0] rp, wp;
   logic [AW:0]   cnt;
   logic          full, pop, push, redirect;
   logic [31:0]   pc_inc, pc_tgt;

   assign full        = (cnt == FULL_CNT);
   assign instr_valid = (cnt != '0);
   assign pop         = instr_valid && instr_ready;
   assign redirect    = branch_taken && (state != IDLE);
   assign pc_inc      = (pc == LAST) ? 32'd0 : pc + 32'd4;
   assign pc_tgt      = (branch_target & 32'hFFFF_FFFC) % SPAN;
   assign imem_addr   = pc;
   assign busy        = (state == FETCH) || (state == FLUSH);
   assign instr       = instr_valid ? fifo_data[rp] : 32'd0;
   assign instr_pc    = instr_valid ? fifo_pc[rp]   : 32'd0;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      push      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !halt) state_nxt = FETCH;
         end
         FETCH: begin
            if (redirect) begin
               state_nxt = FLUSH;
               pc_nxt    = pc_tgt;
            end else if (halt) begin
               state_nxt = HALTED;
            end else if (!full || pop) begin
               push   = 1'b1;
               pc_nxt = pc_inc;
            end
         end
         FLUSH: begin
            if (redirect) begin
               pc_nxt = pc_tgt;
            end else if (halt) begin
               state_nxt = HALTED;
            end else begin
               state_nxt = FETCH;
            end
         end
         HALTED: begin
            if (redirect) pc_nxt = pc_tgt;
            else if (start && !halt) state_nxt = FETCH;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pc    <= PC_RST;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // A redirect drops everything buffered, including an entry popped this cycle.
   always_ff @(posedge clk) begin
      if (reset || redirect) begin
         rp  <= '0;
         wp  <= '0;
         cnt <= '0;
      end else begin
         if (push) begin
            fifo_data[wp] <= imem_data;
            fifo_pc[wp]   <= pc;
            wp            <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
         if (push && !pop) cnt <= cnt + 1'b1;
         else if (pop && !push) cnt <= cnt - 1'b1;
      end
   end

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count    <= '0;
         redirect_count <= '0;
      end else begin
         if (push && fetch_count != '1) fetch_count <= fetch_count + 1'b1;
         if (redirect && redirect_count != '1)
            redirect_count <= redirect_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: latency, stall, redirect, wrap, halt, reset.
// Expected values are hand-computed against a fixed memory image.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, halt;
   logic [31:0] imem_addr, imem_data;
   logic [31:0] instr, instr_pc;
   logic        instr_valid, instr_ready;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        busy;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count;
   logic [15:0] redirect_count;
`endif

   int total = 0;
   int bad   = 0;
   logic [31:0] mem [32];

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr[6:2]];

   fetch_sequencer #(
      .DEPTH(2), .RESET_PC(32'h0), .IMEM_WORDS(32)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .halt(halt),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .branch_taken(branch_taken), .branch_target(branch_target)
`ifdef FETCH_STATS_EN
      , .fetch_count(fetch_count), .redirect_count(redirect_count)
`endif
      , .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; start = 1'b0; halt = 1'b0;
      branch_taken = 1'b0; branch_target = 32'h0;
      tick; tick;
      reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 + i * 32'h111;
      instr_ready = 1'b0;
      do_reset;
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc", instr_pc, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
`ifdef FETCH_STATS_EN
      chk("rst_fcnt", fetch_count, 32'd0);
      chk("rst_rcnt", {16'b0, redirect_count}, 32'd0);
`endif

      // start + halt together: halt wins, stay idle
      start = 1'b1; halt = 1'b1;
      tick;
      start = 1'b0; halt = 1'b0;
      chk("sh_busy", {31'b0, busy}, 32'd0);

      // latency and streaming
      instr_ready = 1'b1; start = 1'b1;
      tick;
      start = 1'b0;
      chk("c1_busy", {31'b0, busy}, 32'd1);
      chk("c1_valid", {31'b0, instr_valid}, 32'd0);
      tick;
      chk("c2_valid", {31'b0, instr_valid}, 32'd1);
      chk("c2_pc", instr_pc, 32'h0);
      chk("c2_instr", instr, mem[0]);
      tick;
      chk("c3_pc", instr_pc, 32'h4);
      chk("c3_instr", instr, mem[1]);
      tick;
      chk("c4_pc", instr_pc, 32'h8);
      chk("c4_instr", instr, mem[2]);

      // redirect with head popped in the same cycle
      branch_taken = 1'b1; branch_target = 32'h13;
      tick;
      branch_taken = 1'b0;
      chk("fl_valid", {31'b0, instr_valid}, 32'd0);
      chk("fl_busy", {31'b0, busy}, 32'd1);
      chk("fl_addr", imem_addr, 32'h10);
      tick;
      chk("fl2_valid", {31'b0, instr_valid}, 32'd0);
      tick;
      chk("br_pc", instr_pc, 32'h10);
      chk("br_instr", instr, mem[4]);

      // wrap from the last word back to zero
      branch_taken = 1'b1; branch_target = 32'h7C;
      tick;
      branch_taken = 1'b0;
      tick; tick;
      chk("wr_pc", instr_pc, 32'h7C);
      chk("wr_addr", imem_addr, 32'h0);
      tick;
      chk("wr_pc0", instr_pc, 32'h0);
      chk("wr_ins0", instr, mem[0]);
`ifdef FETCH_STATS_EN
      chk("rcnt2", {16'b0, redirect_count}, 32'd2);
`endif

      // stall: FIFO fills, address parks at 8
      instr_ready = 1'b0;
      do_reset;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick; tick; tick;
      chk("st_addr", imem_addr, 32'h8);
      chk("st_pc", instr_pc, 32'h0);
      chk("st_instr", instr, mem[0]);
      instr_ready = 1'b1;
      tick;
      chk("st_pc4", instr_pc, 32'h4);
      tick;
      chk("st_pc8", instr_pc, 32'h8);
      chk("st_ins8", instr, mem[2]);
      tick;
      chk("st_pcC", instr_pc, 32'hC);

      // halt while full, drain, resume from held PC
      instr_ready = 1'b0;
      do_reset;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick; tick; tick; tick;
      halt = 1'b1;
      tick;
      halt = 1'b0;
      chk("h_busy", {31'b0, busy}, 32'd0);
      chk("h_addr", imem_addr, 32'h8);
      chk("h_pc0", instr_pc, 32'h0);
      instr_ready = 1'b1;
      tick;
      chk("h_pc4", instr_pc, 32'h4);
      chk("h_addr2", imem_addr, 32'h8);
      tick;
      chk("h_empty", {31'b0, instr_valid}, 32'd0);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("hr_busy", {31'b0, busy}, 32'd1);
      tick;
      chk("hr_pc", instr_pc, 32'h8);
      chk("hr_instr", instr, mem[2]);

      // reset with FIFO full
      instr_ready = 1'b0;
      do_reset;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick; tick;
      chk("rf_valid0", {31'b0, instr_valid}, 32'd1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("rf_valid", {31'b0, instr_valid}, 32'd0);
      chk("rf_addr", imem_addr, 32'h0);
      chk("rf_busy", {31'b0, busy}, 32'd0);

      // reset during FLUSH
      start = 1'b1;
      tick;
      start = 1'b0;
      tick; tick;
      branch_taken = 1'b1; branch_target = 32'h40;
      tick;
      branch_taken = 1'b0;
      chk("rm_addr0", imem_addr, 32'h40);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("rm_valid", {31'b0, instr_valid}, 32'd0);
      chk("rm_addr", imem_addr, 32'h0);
      chk("rm_busy", {31'b0, busy}, 32'd0);
`ifdef FETCH_STATS_EN
      chk("rm_fcnt", fetch_count, 32'd0);
      chk("rm_rcnt", {16'b0, redirect_count}, 32'd0);
`endif

      // branch ignored while idle
      branch_taken = 1'b1; branch_target = 32'h20;
      tick;
      branch_taken = 1'b0;
      chk("id_addr", imem_addr, 32'h0);
      chk("id_busy", {31'b0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
